// File: rtl/amstrad_wait_gen.sv
// Bus-slot strobe and Z80 wait-state generator for the Amstrad motherboard.
// Each CPU access is held until the next slot boundary; I/O and INTack get extra whole slots.
module amstrad_wait_gen #(
    parameter int  SLOT_LEN   = 4,
    parameter int  SLOT_PHASE = 0,
    parameter int  IO_EXTRA   = 1,
    parameter int  CNT_W      = 16,
    localparam int IDX_W      = $clog2(SLOT_LEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             no_wait,
    input  logic             mreq_n,
    input  logic             iorq_n,
    input  logic             rfsh_n,
    input  logic             m1_n,
    input  logic             cnt_clr,
    output logic [IDX_W-1:0] slot_idx,
    output logic             slot_start,
    output logic             wait_n,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLOT,
        WAIT_EXTRA
    } state_t;

    localparam logic [1:0] EXTRA_IO    = 2'(IO_EXTRA);
    localparam logic [1:0] EXTRA_IO_M1 = 2'(IO_EXTRA - 1);

    state_t     state;
    logic [1:0] extra;
    logic       acc_q;
    logic       acc;
    logic       start;
    logic       io_cyc;

    // acc is 1 when the bus is idle; refresh cycles never count as accesses.
    assign acc        = (mreq_n | ~rfsh_n) & iorq_n;
    assign start      = ce & acc_q & ~acc;
    // INTack (M1 with IORQ) is already covered by IORQ alone; the second term is redundant by intent.
    assign io_cyc     = ~iorq_n | (~m1_n & ~iorq_n);
    assign slot_start = ce & (slot_idx == IDX_W'(SLOT_PHASE));

    // NOTE: every register uses non-blocking assignment and the asynchronous reset branch,
    // so a reset mid-wait releases the CPU without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_idx <= '0;
        end else if (ce) begin
            if (slot_idx == IDX_W'(SLOT_LEN - 1)) begin
                slot_idx <= '0;
            end else begin
                slot_idx <= slot_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            wait_n <= 1'b1;
            busy   <= 1'b0;
            extra  <= 2'd0;
            acc_q  <= 1'b1;
        end else if (ce) begin
            acc_q <= acc;
            if (no_wait) begin
                state  <= IDLE;
                wait_n <= 1'b1;
                busy   <= 1'b0;
                extra  <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !slot_start) begin
                            state  <= WAIT_SLOT;
                            wait_n <= 1'b0;
                            busy   <= 1'b1;
                            extra  <= io_cyc ? EXTRA_IO : 2'd0;
                        end else if (start && io_cyc && (IO_EXTRA > 0)) begin
                            // Start on a boundary: the slot wait is already over, only extras remain.
                            state  <= WAIT_EXTRA;
                            wait_n <= 1'b0;
                            busy   <= 1'b1;
                            extra  <= EXTRA_IO_M1;
                        end
                    end
                    WAIT_SLOT: begin
                        if (slot_start) begin
                            if (extra == 2'd0) begin
                                state  <= IDLE;
                                wait_n <= 1'b1;
                                busy   <= 1'b0;
                            end else begin
                                state <= WAIT_EXTRA;
                                extra <= extra - 2'd1;
                            end
                        end
                    end
                    WAIT_EXTRA: begin
                        if (slot_start) begin
                            if (extra == 2'd0) begin
                                state  <= IDLE;
                                wait_n <= 1'b1;
                                busy   <= 1'b0;
                            end else begin
                                extra <= extra - 2'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        wait_n <= 1'b1;
                        busy   <= 1'b0;
                        extra  <= 2'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (ce && !wait_n && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
